// File: rtl/alu_scheduler_pkg.sv
// Shared ALU opcodes, scheduler state encoding and pointer helper.
package alu_scheduler_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5
    } alu_opcode_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_STARVE = 1'b1
    } sched_state_e;

    // Round-robin successor over the secondary ports 1..requesters-1.
    function automatic int unsigned next_rr(int unsigned granted, int unsigned requesters);
        return (granted >= requesters - 1) ? 1 : granted + 1;
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-side bundle: per-port operation requests and the shared response.
interface alu_scheduler_if #(
    parameter int WORD_WIDTH = 32,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]                 req_valid;
    logic [REQUESTERS-1:0]                 req_ready;
    logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_a;
    logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_b;
    logic [REQUESTERS-1:0]                 req_ic;
    logic [REQUESTERS-1:0]                 req_use_carry;
    logic [REQUESTERS-1:0][3:0]            req_opcode;
    logic [REQUESTERS-1:0]                 req_store_flags;
    logic [REQUESTERS-1:0]                 rsp_valid;
    logic [WORD_WIDTH-1:0]                 rsp_result;
    logic                                  rsp_carry;
    logic                                  rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_ic, req_use_carry, req_opcode, req_store_flags,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ic, req_use_carry, req_opcode, req_store_flags,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow
    );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting index at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    localparam int unsigned NU = N;

    int unsigned idx;
    logic        found;

    // Scan N positions starting at ptr; the first set request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = (32'(ptr) + k) % NU;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between the issue port (0) and secondary updaters,
// registers the result back and owns the architectural carry/overflow flags.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int REQUESTERS   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_scheduler_if.slave        req_if,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic                  alu_ic,
    output logic [3:0]            alu_opcode,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_oc,
    input  logic                  alu_oo,
    output logic                  carry_flag,
    output logic                  overflow_flag
);
    localparam int PTR_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W-1:0] LOWEST_SEC = PTR_W'(1);

    sched_state_e                      state;
    logic [PTR_W-1:0]                  rr_ptr, rr_nxt;
    logic [REQUESTERS-1:0][CNT_W-1:0]  wait_cnt, wait_nxt;
    logic [REQUESTERS-1:0]             sec_req, starved, rr_grant, starve_grant, grant;
    logic                              any_starve_nxt;
    logic [WORD_WIDTH-1:0]             hold_a, hold_b;
    logic                              hold_ic, sel_use_carry, sel_ic, sel_store;

    // Secondary requests, and those that have waited long enough to preempt.
    always_comb begin
        sec_req    = req_if.req_valid;
        sec_req[0] = 1'b0;
        for (int unsigned i = 0; i < REQUESTERS; i++)
            starved[i] = sec_req[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
    end

    rr_arbiter #(.N(REQUESTERS)) u_rr_arb (
        .req   (sec_req),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    // Pointer fixed at 1 turns the same arbiter into a lowest-index pick.
    rr_arbiter #(.N(REQUESTERS)) u_starve_arb (
        .req   (starved),
        .ptr   (LOWEST_SEC),
        .grant (starve_grant)
    );

    // One-hot grant; port 0 is locked out for the single STARVE cycle.
    always_comb begin
        grant = '0;
        if (!reset_n)
            grant = '0;
        else if (state == ST_STARVE)
            grant = starve_grant;
        else if (req_if.req_valid[0])
            grant[0] = 1'b1;
        else
            grant = rr_grant;
        req_if.req_ready = grant;
    end

    // ALU bus mux; operands and carry-in hold their last value when nothing is granted.
    always_comb begin
        alu_a         = hold_a;
        alu_b         = hold_b;
        alu_opcode    = OP_NOP;
        sel_ic        = hold_ic;
        sel_use_carry = 1'b0;
        sel_store     = 1'b0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                alu_a         = req_if.req_a[i];
                alu_b         = req_if.req_b[i];
                alu_opcode    = req_if.req_opcode[i];
                sel_ic        = req_if.req_ic[i];
                sel_use_carry = req_if.req_use_carry[i];
                sel_store     = req_if.req_store_flags[i];
            end
        end
        alu_ic = sel_use_carry ? carry_flag : sel_ic;
    end

    // Next wait counts, starvation lookahead and round-robin successor.
    always_comb begin
        wait_nxt       = '0;
        any_starve_nxt = 1'b0;
        rr_nxt         = rr_ptr;
        for (int unsigned i = 1; i < REQUESTERS; i++) begin
            if (!req_if.req_valid[i] || grant[i])
                wait_nxt[i] = '0;
            else if (wait_cnt[i] >= CNT_W'(STARVE_LIMIT))
                wait_nxt[i] = wait_cnt[i];
            else
                wait_nxt[i] = wait_cnt[i] + CNT_W'(1);
            if (wait_nxt[i] >= CNT_W'(STARVE_LIMIT))
                any_starve_nxt = 1'b1;
            if (grant[i])
                rr_nxt = PTR_W'(next_rr(i, REQUESTERS));
        end
    end

    // FSM, counters, response register and architectural flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_NORMAL;
            rr_ptr              <= LOWEST_SEC;
            wait_cnt            <= '0;
            hold_a              <= '0;
            hold_b              <= '0;
            hold_ic             <= 1'b0;
            req_if.rsp_valid    <= '0;
            req_if.rsp_result   <= '0;
            req_if.rsp_carry    <= 1'b0;
            req_if.rsp_overflow <= 1'b0;
            carry_flag          <= 1'b0;
            overflow_flag       <= 1'b0;
        end else begin
            // Entry is decided on the lookahead count so the preempting cycle comes
            // right after STARVE_LIMIT wait cycles.
            if (state == ST_NORMAL && req_if.req_valid[0] && any_starve_nxt)
                state <= ST_STARVE;
            else
                state <= ST_NORMAL;
            wait_cnt         <= wait_nxt;
            rr_ptr           <= rr_nxt;
            req_if.rsp_valid <= grant;
            if (|grant) begin
                hold_a              <= alu_a;
                hold_b              <= alu_b;
                hold_ic             <= alu_ic;
                req_if.rsp_result   <= alu_out;
                req_if.rsp_carry    <= alu_oc;
                req_if.rsp_overflow <= alu_oo;
                if (sel_store) begin
                    carry_flag    <= alu_oc;
                    overflow_flag <= alu_oo;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler with a behavioural ALU and scheduler model.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    localparam int W   = 32;
    localparam int R   = 4;
    localparam int LIM = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_ic, alu_oc, alu_oo;
    logic [3:0]   alu_opcode;
    logic         carry_flag, overflow_flag;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference scheduler state, kept as plain integers.
    int   m_wait[R];
    int   m_rr;
    bit   m_starve;
    logic m_carry, m_ovf, m_rsp_c, m_rsp_o;
    logic [W-1:0] m_rsp;

    always #5 clk = ~clk;

    alu_scheduler_if #(.WORD_WIDTH(W), .REQUESTERS(R)) bif ();

    alu_scheduler #(.WORD_WIDTH(W), .REQUESTERS(R), .STARVE_LIMIT(LIM)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_if        (bif),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ic        (alu_ic),
        .alu_opcode    (alu_opcode),
        .alu_out       (alu_out),
        .alu_oc        (alu_oc),
        .alu_oo        (alu_oo),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    // Behavioural ALU: returns {carry, overflow, result}.
    function automatic logic [W+1:0] alu_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ic);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, o;
        s = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ic};
                r = s[W-1:0]; c = s[W];
                o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ic};
                r = s[W-1:0]; c = s[W];
                o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        return {c, o, r};
    endfunction

    always_comb {alu_oc, alu_oo, alu_out} = alu_ref(alu_opcode, alu_a, alu_b, alu_ic);

    function automatic logic [R-1:0] onehot(int g);
        logic [R-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Which port the rules say should win this cycle (-1: none).
    function automatic int model_grant(logic [R-1:0] v);
        if (m_starve) begin
            for (int i = 1; i < R; i++)
                if (v[i] && m_wait[i] >= LIM) return i;
            return -1;
        end
        if (v[0]) return 0;
        for (int k = 0; k < R - 1; k++) begin
            int i;
            i = 1 + ((m_rr - 1 + k) % (R - 1));
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W+1:0] model_result(int g);
        logic ic;
        ic = bif.req_use_carry[g] ? m_carry : bif.req_ic[g];
        return alu_ref(bif.req_opcode[g], bif.req_a[g], bif.req_b[g], ic);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < R; i++) m_wait[i] = 0;
        m_rr = 1; m_starve = 0;
        m_carry = 1'b0; m_ovf = 1'b0; m_rsp = '0; m_rsp_c = 1'b0; m_rsp_o = 1'b0;
    endtask

    task automatic model_commit(logic [R-1:0] v, int g, logic store, logic [W+1:0] res);
        bit due;
        due = 0;
        for (int i = 1; i < R; i++) begin
            if (g == i || !v[i]) m_wait[i] = 0;
            else if (m_wait[i] < LIM) m_wait[i]++;
            if (m_wait[i] >= LIM) due = 1;
        end
        m_starve = !m_starve && v[0] && due;
        if (g >= 1) m_rr = (g == R - 1) ? 1 : g + 1;
        if (g >= 0) begin
            {m_rsp_c, m_rsp_o, m_rsp} = res;
            if (store) begin m_carry = res[W+1]; m_ovf = res[W]; end
        end
    endtask

    task automatic clear_inputs();
        bif.req_valid = '0; bif.req_a = '0; bif.req_b = '0; bif.req_ic = '0;
        bif.req_use_carry = '0; bif.req_opcode = '0; bif.req_store_flags = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        bif.req_valid = '1;
        @(negedge clk); #1;
        vectors++; if (bif.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", bif.req_ready); end
        vectors++; if ({carry_flag, overflow_flag} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {carry_flag, overflow_flag}); end
        vectors++; if (bif.rsp_valid !== 4'b0000 || bif.rsp_result !== '0) begin miscompares++; $display("FAIL reset_rsp: got %b/%h expected 0000/0", bif.rsp_valid, bif.rsp_result); end
        @(negedge clk);
        reset_n = 1'b1; #1;
        vectors++; if (bif.req_ready !== 4'b0001) begin miscompares++; $display("FAIL release_grant: got %b expected 0001", bif.req_ready); end
        vectors++; if (bif.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL release_rsp: got %b expected 0000", bif.rsp_valid); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL release_first_rsp: got %b expected 0001", bif.rsp_valid); end
    endtask

    task automatic test_add();
        do_reset();
        @(negedge clk);
        bif.req_valid[0] = 1'b1; bif.req_opcode[0] = OP_ADD;
        bif.req_a[0] = 32'd5; bif.req_b[0] = 32'd7; bif.req_store_flags[0] = 1'b1;
        #1;
        vectors++; if (alu_a !== 32'd5 || alu_opcode !== OP_ADD) begin miscompares++; $display("FAIL add_bus: got %h/%h expected 5/%h", alu_a, alu_opcode, OP_ADD); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL add_rsp_valid: got %b expected 0001", bif.rsp_valid); end
        vectors++; if (bif.rsp_result !== 32'd12) begin miscompares++; $display("FAIL add_result: got %0d expected 12", bif.rsp_result); end
        vectors++; if (carry_flag !== 1'b0) begin miscompares++; $display("FAIL add_carry: got %b expected 0", carry_flag); end
        @(negedge clk);
        clear_inputs(); #1;
        vectors++; if (alu_opcode !== OP_NOP || alu_a !== 32'd5) begin miscompares++; $display("FAIL idle_bus_hold: got %h/%h expected %h/5", alu_opcode, alu_a, OP_NOP); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_valid !== 4'b0000 || bif.rsp_result !== 32'd12) begin miscompares++; $display("FAIL idle_rsp_hold: got %b/%0d expected 0000/12", bif.rsp_valid, bif.rsp_result); end
    endtask

    task automatic test_carry_chain();
        do_reset();
        @(negedge clk);
        bif.req_valid[0] = 1'b1; bif.req_opcode[0] = OP_ADD;
        bif.req_a[0] = 32'hFFFF_FFFF; bif.req_b[0] = 32'd1; bif.req_store_flags[0] = 1'b1;
        @(posedge clk); #1;
        vectors++; if (carry_flag !== 1'b1 || bif.rsp_result !== 32'd0) begin miscompares++; $display("FAIL chain_first: got c=%b r=%h expected c=1 r=0", carry_flag, bif.rsp_result); end
        @(negedge clk);
        bif.req_a[0] = '0; bif.req_b[0] = '0; bif.req_use_carry[0] = 1'b1; bif.req_store_flags[0] = 1'b0;
        #1;
        vectors++; if (alu_ic !== 1'b1) begin miscompares++; $display("FAIL chain_ic: got %b expected 1", alu_ic); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_result !== 32'd1) begin miscompares++; $display("FAIL chain_second: got %h expected 1", bif.rsp_result); end
    endtask

    task automatic test_round_robin();
        logic [R-1:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bif.req_valid = 4'b1110; #1;
            vectors++; if (bif.req_ready !== exp_seq[c]) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, bif.req_ready, exp_seq[c]); end
            @(posedge clk); #1;
            vectors++; if (bif.rsp_valid !== exp_seq[c]) begin miscompares++; $display("FAIL rr_rsp[%0d]: got %b expected %b", c, bif.rsp_valid, exp_seq[c]); end
        end
    endtask

    task automatic test_starve();
        logic [R-1:0] exp;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bif.req_valid = 4'b0101; #1;
            // Eight wait cycles, then one preempting cycle; the count restarts after the grant.
            exp = (c == 9 || c == 18) ? 4'b0100 : 4'b0001;
            vectors++; if (bif.req_ready !== exp) begin miscompares++; $display("FAIL starve_grant[%0d]: got %b expected %b", c, bif.req_ready, exp); end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        @(negedge clk);
        bif.req_valid[0] = 1'b1; bif.req_opcode[0] = OP_ADD; bif.req_store_flags[0] = 1'b1;
        bif.req_a[0] = 32'hFFFF_FFFF; bif.req_b[0] = 32'd1;
        @(negedge clk);
        bif.req_a[0] = 32'd1; bif.req_b[0] = 32'd1; #1;
        reset_n = 1'b0; #1;
        vectors++; if ({carry_flag, overflow_flag} !== 2'b00 || bif.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL inflight_async: got flags=%b rsp=%b expected 00/0000", {carry_flag, overflow_flag}, bif.rsp_valid); end
        vectors++; if (bif.req_ready !== 4'b0000) begin miscompares++; $display("FAIL inflight_ready: got %b expected 0000", bif.req_ready); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL inflight_dropped: got %b expected 0000", bif.rsp_valid); end
        @(negedge clk);
        reset_n = 1'b1; #1;
        vectors++; if (bif.rsp_valid !== 4'b0000 || bif.req_ready !== 4'b0001) begin miscompares++; $display("FAIL inflight_release: got rsp=%b ready=%b expected 0000/0001", bif.rsp_valid, bif.req_ready); end
        @(posedge clk); #1;
        vectors++; if (bif.rsp_result !== 32'd2) begin miscompares++; $display("FAIL inflight_after: got %h expected 2", bif.rsp_result); end
    endtask

    task automatic test_random(int cycles);
        logic [R-1:0] v;
        logic [W+1:0] res;
        logic         st;
        int           g, thr;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            thr = ((c / 40) % 2 == 0) ? 7 : 3;
            for (int i = 0; i < R; i++) begin
                bif.req_valid[i]       = ($urandom_range(0, 7) < ((i == 0) ? 6 : thr));
                bif.req_a[i]           = $urandom;
                bif.req_b[i]           = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 3));
                bif.req_ic[i]          = 1'($urandom_range(0, 1));
                bif.req_use_carry[i]   = 1'($urandom_range(0, 1));
                bif.req_opcode[i]      = 4'($urandom_range(0, 5));
                bif.req_store_flags[i] = 1'($urandom_range(0, 1));
            end
            #1;
            v   = bif.req_valid;
            g   = model_grant(v);
            res = (g >= 0) ? model_result(g) : '0;
            st  = (g >= 0) ? bif.req_store_flags[g] : 1'b0;
            vectors++; if (bif.req_ready !== onehot(g)) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bif.req_ready, onehot(g)); end
            vectors++; if (alu_opcode !== ((g >= 0) ? bif.req_opcode[g] : OP_NOP)) begin miscompares++; $display("FAIL rand_opcode[%0d]: got %h", c, alu_opcode); end
            @(posedge clk); #1;
            model_commit(v, g, st, res);
            vectors++; if (bif.rsp_valid !== onehot(g)) begin miscompares++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", c, bif.rsp_valid, onehot(g)); end
            vectors++; if ({bif.rsp_carry, bif.rsp_overflow, bif.rsp_result} !== {m_rsp_c, m_rsp_o, m_rsp}) begin miscompares++; $display("FAIL rand_rsp_data[%0d]: got %b%b %h expected %b%b %h", c, bif.rsp_carry, bif.rsp_overflow, bif.rsp_result, m_rsp_c, m_rsp_o, m_rsp); end
            vectors++; if ({carry_flag, overflow_flag} !== {m_carry, m_ovf}) begin miscompares++; $display("FAIL rand_flags[%0d]: got %b expected %b", c, {carry_flag, overflow_flag}, {m_carry, m_ovf}); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_round_robin();
        test_starve();
        test_reset_inflight();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
